// File: rtl/switch_allocator_pkg.sv
// Router-wide NoC constants and the port encoding shared by the switch allocator.
package noc_params;

    typedef enum logic [3:0] {
        NORTH = 4'd0,
        SOUTH = 4'd1,
        EAST  = 4'd2,
        WEST  = 4'd3,
        DLA0  = 4'd4,
        DLA1  = 4'd5,
        DLA2  = 4'd6,
        DLA3  = 4'd7,
        SKIP  = 4'd8
    } port_t;

    localparam int PORT_NUM      = 9;
    localparam int BUFFER_DEPTH  = 4;
    localparam int PORT_SEL_SIZE = $clog2(PORT_NUM);
    localparam int CREDIT_W      = $clog2(BUFFER_DEPTH + 1);

endpackage

// File: rtl/switch_allocator_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 9,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = W'(j);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Wormhole switch allocator: per-output lock, round-robin, credits, registered xbar select.
// Optional SA_CREDIT_CHECK_EN adds a sticky credit_err_o.
module switch_allocator
    import noc_params::*;
(
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [PORT_NUM-1:0]                     req_i,
    input  port_t [PORT_NUM-1:0]                    out_port_i,
    input  logic [PORT_NUM-1:0]                     head_i,
    input  logic [PORT_NUM-1:0]                     tail_i,
    input  logic [PORT_NUM-1:0]                     credit_inc_i,
    output logic [PORT_NUM-1:0]                     grant_o,
    output logic [PORT_NUM-1:0][PORT_SEL_SIZE-1:0]  xbar_sel_o,
`ifdef SA_CREDIT_CHECK_EN
    output logic                                    credit_err_o,
`endif
    output logic [PORT_NUM-1:0]                     xbar_valid_o
);

    logic [PORT_NUM-1:0]                     locked;
    logic [PORT_NUM-1:0][PORT_SEL_SIZE-1:0]  owner;
    logic [PORT_NUM-1:0][PORT_SEL_SIZE-1:0]  rr_ptr;
    logic [PORT_NUM-1:0][CREDIT_W-1:0]       credit;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]       elig;
    logic [PORT_NUM-1:0][PORT_NUM-1:0]       ogrant;
    logic [PORT_NUM-1:0][PORT_SEL_SIZE-1:0]  widx;
    logic [PORT_NUM-1:0]                     won;

    for (genvar o = 0; o < PORT_NUM; o++) begin : g_out
        for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
            // rst_n gating keeps grant_o quiet for the whole reset window
            assign elig[o][i] = rst_n && req_i[i] && (out_port_i[i] == port_t'(o))
                              && (credit[o] != '0)
                              && (locked[o] ? (owner[o] == PORT_SEL_SIZE'(i)) : head_i[i]);
        end

        rr_arbiter #(.N(PORT_NUM), .W(PORT_SEL_SIZE)) u_arb (
            .req (elig[o]),
            .ptr (rr_ptr[o]),
            .gnt (ogrant[o]),
            .idx (widx[o]),
            .any (won[o])
        );
    end

    // Each input names one output, so OR-ing the per-output grants never collides.
    always_comb begin
        grant_o = '0;
        for (int o = 0; o < PORT_NUM; o++) grant_o = grant_o | ogrant[o];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked       <= '0;
            owner        <= '0;
            rr_ptr       <= '0;
            credit       <= {PORT_NUM{CREDIT_W'(BUFFER_DEPTH)}};
            xbar_valid_o <= '0;
            xbar_sel_o   <= '0;
        end else begin
            for (int o = 0; o < PORT_NUM; o++) begin
                xbar_valid_o[o] <= won[o];
                if (won[o]) begin
                    xbar_sel_o[o] <= widx[o];
                    // Pointer moves only at packet end so a locked packet is never preempted
                    if (tail_i[widx[o]]) begin
                        locked[o] <= 1'b0;
                        rr_ptr[o] <= (widx[o] == PORT_SEL_SIZE'(PORT_NUM - 1))
                                   ? '0 : widx[o] + 1'b1;
                    end else if (head_i[widx[o]]) begin
                        locked[o] <= 1'b1;
                        owner[o]  <= widx[o];
                    end
                end
                if (credit_inc_i[o] && !won[o]) begin
                    if (credit[o] != CREDIT_W'(BUFFER_DEPTH)) credit[o] <= credit[o] + 1'b1;
                end else if (won[o] && !credit_inc_i[o]) begin
                    credit[o] <= credit[o] - 1'b1;
                end
            end
        end
    end

`ifdef SA_CREDIT_CHECK_EN
    logic [PORT_NUM-1:0] cr_full, cr_empty;
    logic                err_set;

    always_comb begin
        cr_full  = '0;
        cr_empty = '0;
        for (int o = 0; o < PORT_NUM; o++) begin
            cr_full[o]  = (credit[o] == CREDIT_W'(BUFFER_DEPTH));
            cr_empty[o] = (credit[o] == '0);
        end
        err_set = |((credit_inc_i & ~won & cr_full) | (won & cr_empty));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) credit_err_o <= 1'b0;
        else        credit_err_o <= credit_err_o | err_set;
    end
`endif

endmodule
